instruction_fetcher: RTL

Per-core instruction fetch unit. It reads the PC selected by the program counter unit, requests that instruction from the program memory controller over a valid/ready read channel, and presents the fetched word to the decoder. A one-entry last-instruction buffer serves a repeated PC, such as a branch-to-self spin loop, without a memory transaction. It sits between the core scheduler (core_state), the PC unit (current_pc) and the program memory controller.

---
 rtl/instruction_fetcher.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instruction_fetcher.sv
// Instruction fetch unit with a one-entry last-instruction buffer: a hit is FETCHED 1 edge after FETCH,
// a miss takes 2+ cycles. The read request is held until the controller's ready.
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_FETCHING = 3'b001,
        ST_FETCHED  = 3'b010
    } fetch_state_t;

    fetch_state_t                     state_q, state_d;
    logic                             mem_read_valid_q, mem_read_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address_q, mem_read_address_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_q, instruction_d;
    logic                             buf_valid_q, buf_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_tag_q, buf_tag_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data_q, buf_data_d;
    logic                             drop_fill_q, drop_fill_d;

    logic buf_hit;
    assign buf_hit = buf_valid_q && (buf_tag_q == current_pc) && !cache_invalidate;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            instruction_q      <= '0;
            buf_valid_q        <= 1'b0;
            buf_tag_q          <= '0;
            buf_data_q         <= '0;
            drop_fill_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            instruction_q      <= instruction_d;
            buf_valid_q        <= buf_valid_d;
            buf_tag_q          <= buf_tag_d;
            buf_data_q         <= buf_data_d;
            drop_fill_q        <= drop_fill_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        instruction_d      = instruction_q;
        buf_valid_d        = buf_valid_q;
        buf_tag_d          = buf_tag_q;
        buf_data_d         = buf_data_q;
        drop_fill_d        = drop_fill_q;

        case (state_q)
            ST_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (buf_hit) begin
                        instruction_d = buf_data_q;
                        state_d       = ST_FETCHED;
                    end else begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = current_pc;
                        drop_fill_d        = cache_invalidate;
                        state_d            = ST_FETCHING;
                    end
                end
            end
            ST_FETCHING: begin
                if (cache_invalidate) begin
                    drop_fill_d = 1'b1;
                end
                // An invalidate racing the fill delivers the word but leaves it uncached.
                if (mem_read_ready && mem_read_valid_q) begin
                    instruction_d    = mem_read_data;
                    mem_read_valid_d = 1'b0;
                    buf_tag_d        = mem_read_address_q;
                    buf_data_d       = mem_read_data;
                    buf_valid_d      = !(drop_fill_q || cache_invalidate);
                    state_d          = ST_FETCHED;
                end
            end
            ST_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d          = ST_IDLE;
                mem_read_valid_d = 1'b0;
            end
        endcase

        if (cache_invalidate) begin
            buf_valid_d = 1'b0;
        end
    end

    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign fetcher_state    = state_q;
    assign instruction      = instruction_q;
endmodule
